// File: rtl/banco_registros_param_if.sv
// Bus bundle for the register file: two read ports, one write port, clear control and status.
interface banco_registros_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr_1;
   logic [ADDR_W-1:0] rd_addr_2;
   logic [DATA_W-1:0] rd_data_1;
   logic [DATA_W-1:0] rd_data_2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr;
   logic              busy;
   logic              wr_drop;

   modport master (
      output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, clr,
      input  rd_data_1, rd_data_2, busy, wr_drop
   );

   modport slave (
      input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, clr,
      output rd_data_1, rd_data_2, busy, wr_drop
   );
endinterface

// File: rtl/banco_registros_param.sv
// Architectural register file: two combinational read ports with write bypass, one clocked
// write port, optional hardwired zero register and a one-register-per-cycle clear sweep.
module banco_registros_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   banco_registros_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              wr_drop_q, wr_drop_d;

   logic                          busy;
   logic                          wr_accept;
   logic                          byp_ok;
   logic [DEPTH-1:0][DATA_W-1:0]  regs_w;

   assign busy = (state_q == ST_CLEAR);

   // A write lands only from IDLE without a simultaneous clear request; r0 writes vanish quietly.
   assign wr_accept = !busy && !bus.clr && bus.wr_en &&
                      !(ZERO_REG && (bus.wr_addr == '0));
   assign wr_drop_d = bus.wr_en && (busy || bus.clr);
   assign byp_ok    = !busy && !bus.clr && bus.wr_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == {ADDR_W{1'b1}}) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // One register per slot so each word has its own reset, sweep and write decode.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic [DATA_W-1:0] word_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_q <= '0;
            end else if (busy && (cnt_q == ADDR_W'(gi))) begin
               word_q <= '0;
            end else if (wr_accept && (bus.wr_addr == ADDR_W'(gi))) begin
               word_q <= bus.wr_data;
            end
         end

         assign regs_w[gi] = word_q;
      end
   endgenerate

   assign bus.rd_data_1 = (ZERO_REG && (bus.rd_addr_1 == '0))         ? '0          :
                          (byp_ok && (bus.wr_addr == bus.rd_addr_1))   ? bus.wr_data :
                                                                         regs_w[bus.rd_addr_1];
   assign bus.rd_data_2 = (ZERO_REG && (bus.rd_addr_2 == '0))         ? '0          :
                          (byp_ok && (bus.wr_addr == bus.rd_addr_2))   ? bus.wr_data :
                                                                         regs_w[bus.rd_addr_2];

   assign bus.busy    = busy;
   assign bus.wr_drop = wr_drop_q;
endmodule
